// File: rtl/control_pkg.sv
// control_pkg: opcode map, ALU/write-back encodings and the per-stage control bundle.
package control_pkg;

    localparam int unsigned NUM_OPS = 14;
    localparam int ALU_OP_W = 3;
    localparam int WB_SEL_W = 2;

    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_OR   = 2;
    localparam int unsigned OP_NOR  = 3;
    localparam int unsigned OP_AND  = 4;
    localparam int unsigned OP_ADDI = 5;
    localparam int unsigned OP_ORI  = 6;
    localparam int unsigned OP_NORI = 7;
    localparam int unsigned OP_ANDI = 8;
    localparam int unsigned OP_LW   = 9;
    localparam int unsigned OP_SW   = 10;
    localparam int unsigned OP_J    = 11;
    localparam int unsigned OP_CALL = 12;
    localparam int unsigned OP_JR   = 13;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd4;

    localparam logic [WB_SEL_W-1:0] WB_ALU = 2'd0;
    localparam logic [WB_SEL_W-1:0] WB_MEM = 2'd1;
    localparam logic [WB_SEL_W-1:0] WB_PC  = 2'd2;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
        logic                mem_rd;
        logic                mem_wr;
        logic [WB_SEL_W-1:0] wb_sel;
        logic                reg_sel;
        logic                illegal;
    } ctrl_t;

endpackage

// File: rtl/control_decoder.sv
// control_decoder: combinational opcode-to-control-bundle decode.
module control_decoder
    import control_pkg::*;
#(
    parameter int OPCODE_W = 5
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_t               ctrl_o,
    output logic                reg_r2_o,
    output logic                ext_op_o
);

    int unsigned op;
    logic        illegal;

    // Illegal opcodes decode to an all-zero bundle carrying only the illegal flag.
    always_comb begin
        op                = 32'(opcode_i);
        illegal           = op >= NUM_OPS;
        ctrl_o            = '0;
        ctrl_o.illegal    = illegal;
        ctrl_o.valid      = !illegal;
        ctrl_o.reg_write  = !illegal && (op <= OP_ANDI || op == OP_LW || op == OP_CALL);
        ctrl_o.alu_src    = op >= OP_ADDI && op <= OP_SW;
        ctrl_o.alu_op     = (op == OP_SUB) ? ALU_SUB :
                            (op == OP_OR  || op == OP_ORI)  ? ALU_OR  :
                            (op == OP_NOR || op == OP_NORI) ? ALU_NOR :
                            (op == OP_AND || op == OP_ANDI) ? ALU_AND : ALU_ADD;
        ctrl_o.mem_rd     = op == OP_LW;
        ctrl_o.mem_wr     = op == OP_SW;
        ctrl_o.wb_sel     = (op == OP_LW) ? WB_MEM : (op == OP_CALL) ? WB_PC : WB_ALU;
        ctrl_o.reg_sel    = op == OP_CALL;
        reg_r2_o          = op == OP_SW;
        ext_op_o          = op == OP_ADDI || op == OP_LW || op == OP_SW;
    end

endmodule

// File: rtl/pipelined_main_control.sv
// pipelined_main_control: decodes the ID opcode and carries the control bundle through EX, MEM and WB.
module pipelined_main_control
    import control_pkg::*;
#(
    parameter int OPCODE_W     = 5,
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_W-1:0]     opcode_i,
    input  logic                    id_valid_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic                    id_reg_r2_o,
    output logic                    id_ext_op_o,
    output logic                    ex_alu_src_o,
    output logic [ALU_OP_W-1:0]     ex_alu_op_o,
    output logic                    ex_mem_rd_o,
    output logic                    ex_reg_write_o,
    output logic                    mem_mem_rd_o,
    output logic                    mem_mem_wr_o,
    output logic                    mem_reg_write_o,
    output logic                    wb_reg_write_o,
    output logic [WB_SEL_W-1:0]     wb_sel_o,
    output logic                    wb_reg_sel_o,
    output logic                    illegal_o,
    output logic [RETIRE_CNT_W-1:0] retired_cnt_o
);

    ctrl_t                   dec;
    ctrl_t                   ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
    logic [RETIRE_CNT_W-1:0] cnt_d, cnt_q;
    logic                    unused;

    control_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
        .opcode_i (opcode_i),
        .ctrl_o   (dec),
        .reg_r2_o (id_reg_r2_o),
        .ext_op_o (id_ext_op_o)
    );

    // A stalled, flushed or empty ID slot becomes a bubble; illegal opcodes already decode to one.
    always_comb begin
        ex_d  = (stall_i || flush_i || !id_valid_i) ? '0 : dec;
        mem_d = ex_q;
        wb_d  = mem_q;
        cnt_d = cnt_q + RETIRE_CNT_W'(wb_q.valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_alu_src_o    = ex_q.alu_src;
    assign ex_alu_op_o     = ex_q.alu_op;
    assign ex_mem_rd_o     = ex_q.mem_rd;
    assign ex_reg_write_o  = ex_q.reg_write;
    assign illegal_o       = ex_q.illegal;
    assign mem_mem_rd_o    = mem_q.mem_rd;
    assign mem_mem_wr_o    = mem_q.mem_wr;
    assign mem_reg_write_o = mem_q.reg_write;
    assign wb_reg_write_o  = wb_q.reg_write;
    assign wb_sel_o        = wb_q.wb_sel;
    assign wb_reg_sel_o    = wb_q.reg_sel;
    assign retired_cnt_o   = cnt_q;
    assign unused          = ^{wb_q.alu_src, wb_q.alu_op, wb_q.mem_rd, wb_q.mem_wr, wb_q.illegal};

endmodule

// File: tb/tb_pipelined_main_control.sv
// tb_pipelined_main_control: directed vectors against a 32-bit and a 4-bit-counter instance.
module tb_pipelined_main_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] opcode = '0;
    logic       id_valid = 1'b0, stall = 1'b0, flush = 1'b0;

    logic        id_reg_r2, id_ext_op, ex_alu_src, ex_mem_rd, ex_reg_write;
    logic [2:0]  ex_alu_op;
    logic        mem_mem_rd, mem_mem_wr, mem_reg_write, wb_reg_write, wb_reg_sel, illegal;
    logic [1:0]  wb_sel;
    logic [31:0] cnt;

    logic        s_id_reg_r2, s_id_ext_op, s_ex_alu_src, s_ex_mem_rd, s_ex_reg_write;
    logic [2:0]  s_ex_alu_op;
    logic        s_mem_mem_rd, s_mem_mem_wr, s_mem_reg_write, s_wb_reg_write, s_wb_reg_sel, s_illegal;
    logic [1:0]  s_wb_sel;
    logic [3:0]  s_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipelined_main_control dut (
        .clk(clk), .reset(reset), .opcode_i(opcode), .id_valid_i(id_valid),
        .stall_i(stall), .flush_i(flush), .id_reg_r2_o(id_reg_r2), .id_ext_op_o(id_ext_op),
        .ex_alu_src_o(ex_alu_src), .ex_alu_op_o(ex_alu_op), .ex_mem_rd_o(ex_mem_rd),
        .ex_reg_write_o(ex_reg_write), .mem_mem_rd_o(mem_mem_rd), .mem_mem_wr_o(mem_mem_wr),
        .mem_reg_write_o(mem_reg_write), .wb_reg_write_o(wb_reg_write), .wb_sel_o(wb_sel),
        .wb_reg_sel_o(wb_reg_sel), .illegal_o(illegal), .retired_cnt_o(cnt)
    );

    pipelined_main_control #(.RETIRE_CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .opcode_i(opcode), .id_valid_i(id_valid),
        .stall_i(stall), .flush_i(flush), .id_reg_r2_o(s_id_reg_r2), .id_ext_op_o(s_id_ext_op),
        .ex_alu_src_o(s_ex_alu_src), .ex_alu_op_o(s_ex_alu_op), .ex_mem_rd_o(s_ex_mem_rd),
        .ex_reg_write_o(s_ex_reg_write), .mem_mem_rd_o(s_mem_mem_rd), .mem_mem_wr_o(s_mem_mem_wr),
        .mem_reg_write_o(s_mem_reg_write), .wb_reg_write_o(s_wb_reg_write), .wb_sel_o(s_wb_sel),
        .wb_reg_sel_o(s_wb_reg_sel), .illegal_o(s_illegal), .retired_cnt_o(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic [4:0] op, input logic v, input logic s, input logic f);
        opcode = op; id_valid = v; stall = s; flush = f;
        @(posedge clk);
        #1;
    endtask

    int          alu_ops [6] = '{1, 6, 3, 8, 11, 13};
    logic [31:0] alu_exp [6] = '{1, 2, 3, 4, 0, 0};
    logic [31:0] rw_exp  [6] = '{1, 1, 1, 1, 0, 0};

    initial begin
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("rst_ex_reg_write", 32'(ex_reg_write), 0);
        check("rst_ex_alu_src", 32'(ex_alu_src), 0);
        check("rst_mem_mem_wr", 32'(mem_mem_wr), 0);
        check("rst_wb_reg_write", 32'(wb_reg_write), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_cnt", cnt, 0);
        reset = 1'b0;

        step(0, 1, 0, 0);
        check("add_ex_alu_op", 32'(ex_alu_op), 0);
        check("add_ex_alu_src", 32'(ex_alu_src), 0);
        check("add_ex_reg_write", 32'(ex_reg_write), 1);
        step(9, 1, 0, 0);
        check("lw_ex_alu_src", 32'(ex_alu_src), 1);
        check("lw_ex_mem_rd", 32'(ex_mem_rd), 1);
        check("add_mem_mem_rd", 32'(mem_mem_rd), 0);
        step(10, 1, 0, 0);
        check("sw_ex_alu_src", 32'(ex_alu_src), 1);
        check("lw_mem_mem_rd", 32'(mem_mem_rd), 1);
        check("add_wb_sel", 32'(wb_sel), 0);
        check("add_wb_reg_write", 32'(wb_reg_write), 1);
        step(12, 1, 0, 0);
        check("call_ex_alu_src", 32'(ex_alu_src), 0);
        check("sw_mem_mem_wr", 32'(mem_mem_wr), 1);
        check("lw_wb_sel", 32'(wb_sel), 1);
        check("lw_wb_reg_write", 32'(wb_reg_write), 1);
        check("cnt_1", cnt, 1);
        step(0, 0, 0, 0);
        check("idle_ex_reg_write", 32'(ex_reg_write), 0);
        check("call_mem_reg_write", 32'(mem_reg_write), 1);
        check("call_mem_mem_wr", 32'(mem_mem_wr), 0);
        check("sw_wb_reg_write", 32'(wb_reg_write), 0);
        check("cnt_2", cnt, 2);
        step(0, 0, 0, 0);
        check("call_wb_sel", 32'(wb_sel), 2);
        check("call_wb_reg_sel", 32'(wb_reg_sel), 1);
        check("call_wb_reg_write", 32'(wb_reg_write), 1);
        check("cnt_3", cnt, 3);
        step(0, 0, 0, 0);
        check("cnt_4", cnt, 4);

        for (int i = 0; i < 6; i++) begin
            step(5'(alu_ops[i]), 1, 0, 0);
            check($sformatf("alu_op_%0d", alu_ops[i]), 32'(ex_alu_op), alu_exp[i]);
            check($sformatf("reg_write_%0d", alu_ops[i]), 32'(ex_reg_write), rw_exp[i]);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("cnt_jumps", cnt, 10);

        step(9, 1, 0, 0);
        check("stall_lw_ex_mem_rd", 32'(ex_mem_rd), 1);
        step(0, 1, 1, 0);
        check("stall_ex_reg_write", 32'(ex_reg_write), 0);
        check("stall_ex_mem_rd", 32'(ex_mem_rd), 0);
        check("stall_mem_mem_rd", 32'(mem_mem_rd), 1);
        step(0, 0, 0, 0);
        check("bubble_mem_reg_write", 32'(mem_reg_write), 0);
        check("stall_lw_wb_sel", 32'(wb_sel), 1);
        step(0, 0, 0, 0);
        check("bubble_wb_reg_write", 32'(wb_reg_write), 0);
        check("cnt_after_lw", cnt, 11);
        step(0, 0, 0, 0);
        check("cnt_bubble", cnt, 11);

        step(20, 1, 0, 0);
        check("illegal_pulse", 32'(illegal), 1);
        check("illegal_ex_reg_write", 32'(ex_reg_write), 0);
        step(0, 0, 0, 0);
        check("illegal_drop", 32'(illegal), 0);
        check("illegal_mem_mem_wr", 32'(mem_mem_wr), 0);
        check("illegal_mem_reg_write", 32'(mem_reg_write), 0);
        step(0, 0, 0, 0);
        check("illegal_wb_reg_write", 32'(wb_reg_write), 0);
        step(14, 1, 0, 0);
        check("illegal_14", 32'(illegal), 1);
        step(13, 1, 0, 0);
        check("jr_legal", 32'(illegal), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("cnt_illegal", cnt, 12);

        step(20, 1, 0, 1);
        check("illegal_flush", 32'(illegal), 0);
        step(20, 1, 1, 0);
        check("illegal_stall", 32'(illegal), 0);
        step(20, 1, 1, 1);
        check("illegal_both", 32'(illegal), 0);
        step(20, 0, 0, 0);
        check("illegal_invalid", 32'(illegal), 0);

        opcode = 10; stall = 1; flush = 1; #1;
        check("id_r2_sw", 32'(id_reg_r2), 1);
        check("id_ext_sw", 32'(id_ext_op), 1);
        opcode = 5; #1;
        check("id_r2_addi", 32'(id_reg_r2), 0);
        check("id_ext_addi", 32'(id_ext_op), 1);
        opcode = 0; #1;
        check("id_ext_add", 32'(id_ext_op), 0);

        step(10, 1, 0, 0);
        step(0, 1, 0, 0);
        check("pre_rst_mem_wr", 32'(mem_mem_wr), 1);
        reset = 1'b1;
        step(0, 1, 0, 0);
        check("mid_rst_mem_wr", 32'(mem_mem_wr), 0);
        check("mid_rst_ex_reg_write", 32'(ex_reg_write), 0);
        check("mid_rst_wb_reg_write", 32'(wb_reg_write), 0);
        check("mid_rst_cnt", cnt, 0);
        check("mid_rst_small_cnt", 32'(s_cnt), 0);
        reset = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("post_rst_wb_reg_write", 32'(wb_reg_write), 0);
        check("post_rst_cnt", cnt, 0);

        for (int i = 0; i < 17; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("wrap_small_cnt", 32'(s_cnt), 1);
        check("wrap_big_cnt", cnt, 17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
